// File: rtl/riscv_pkg.sv
// Shared core types: trace capture record, packer FSM states and header layout.
package riscv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned SEQ_W       = 8;
    localparam int unsigned RADDR_W     = 5;
    localparam int unsigned TWORD_W     = 32;
    localparam int unsigned HDR_SEQ_LSB = 24;
    localparam int unsigned HDR_RD_LSB  = 8;
    localparam int unsigned HDR_RDV_BIT = 1;
    localparam int unsigned HDR_MW_BIT  = 0;

    typedef struct packed {
        logic [SEQ_W-1:0]   seq;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    instr;
        logic [RADDR_W-1:0] reg_addr;
        logic [XLEN-1:0]    reg_data;
        logic               mem_wrt;
        logic [XLEN-1:0]    mem_addr;
        logic [XLEN-1:0]    mem_data;
    } trace_rec_t;

    localparam int unsigned TRACE_REC_W = $bits(trace_rec_t);

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_HDR,
        TS_PC,
        TS_INSTR,
        TS_RDATA,
        TS_MADDR,
        TS_MDATA
    } trace_state_e;

    function automatic logic [TWORD_W-1:0] trace_hdr(input trace_rec_t r);
        logic [TWORD_W-1:0] w;
        w                          = '0;
        w[HDR_SEQ_LSB +: SEQ_W]    = r.seq;
        w[HDR_RD_LSB +: RADDR_W]   = r.reg_addr;
        w[HDR_RDV_BIT]             = (r.reg_addr != '0);
        w[HDR_MW_BIT]              = r.mem_wrt;
        return w;
    endfunction

    // Word presented on the stream while the packer sits in state s.
    function automatic logic [TWORD_W-1:0] trace_word(input trace_state_e s, input trace_rec_t r);
        logic [TWORD_W-1:0] w;
        w = '0;
        case (s)
            TS_HDR:   w = trace_hdr(r);
            TS_PC:    w = TWORD_W'(r.pc);
            TS_INSTR: w = TWORD_W'(r.instr);
            TS_RDATA: w = TWORD_W'(r.reg_data);
            TS_MADDR: w = TWORD_W'(r.mem_addr);
            TS_MDATA: w = TWORD_W'(r.mem_data);
            default:  w = '0;
        endcase
        return w;
    endfunction

    function automatic logic trace_is_last(input trace_state_e s, input trace_rec_t r);
        logic l;
        l = 1'b0;
        case (s)
            TS_INSTR: l = (r.reg_addr == '0) && !r.mem_wrt;
            TS_RDATA: l = !r.mem_wrt;
            TS_MDATA: l = 1'b1;
            default:  l = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, no fall-through; also exposes the head entry as it will be after this edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [WIDTH-1:0]         rdata_nxt_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        cnt_d    = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // If the FIFO drains to nothing on this edge, the incoming word becomes the new head.
    always_comb begin
        rdata_o     = mem_q[rd_ptr_q];
        rdata_nxt_o = mem_q[rd_ptr_d];
        if (push_i && (cnt_q == CW'(pop_i))) begin
            rdata_nxt_o = wdata_i;
        end
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/trace_packer.sv
// Retirement-trace capture: buffers commit records and serialises each as a 3..6 word packet.
module trace_packer
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    update_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [XLEN-1:0]         instr_i,
    input  logic [4:0]              reg_addr_i,
    input  logic [XLEN-1:0]         reg_data_i,
    input  logic                    mem_wrt_i,
    input  logic [XLEN-1:0]         mem_addr_i,
    input  logic [XLEN-1:0]         mem_data_i,
    output logic                    trace_valid_o,
    output logic [31:0]             trace_data_o,
    output logic                    trace_last_o,
    input  logic                    trace_ready_i,
    output logic [$clog2(DEPTH):0]  level_o,
    output logic                    overflow_o,
    output logic [CNT_W-1:0]        drop_cnt_o
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    trace_state_e       state_q, state_d;
    logic [SEQ_W-1:0]   seq_q;
    logic [CNT_W-1:0]   drop_q;
    logic               ovf_q;
    logic               valid_q, valid_d;
    logic [31:0]        data_q, data_d;
    logic               last_q, last_d;

    trace_rec_t         rec_in, head, head_nxt;
    logic [TRACE_REC_W-1:0] fifo_rdata, fifo_rdata_nxt;
    logic               fifo_full, fifo_empty, fifo_push;
    logic [LVL_W-1:0]   fifo_count;
    logic               fire, pkt_done, more_pkts;
    trace_state_e       end_state;

    assign rec_in = '{seq:      seq_q,
                      pc:       pc_i,
                      instr:    instr_i,
                      reg_addr: reg_addr_i,
                      reg_data: reg_data_i,
                      mem_wrt:  mem_wrt_i,
                      mem_addr: mem_addr_i,
                      mem_data: mem_data_i};

    // A full FIFO still takes a record when the head's last word leaves on the same edge.
    assign fire      = valid_q && trace_ready_i;
    assign pkt_done  = fire && last_q;
    assign fifo_push = update_i && (!fifo_full || pkt_done);

    sync_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (fifo_push),
        .wdata_i     (rec_in),
        .pop_i       (pkt_done),
        .rdata_o     (fifo_rdata),
        .rdata_nxt_o (fifo_rdata_nxt),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign head      = fifo_rdata;
    assign head_nxt  = fifo_rdata_nxt;
    assign more_pkts = (fifo_count > LVL_W'(1)) || fifo_push;
    assign end_state = more_pkts ? TS_HDR : TS_IDLE;

    // State and registered stream outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= TS_IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Next-state: walk the packet words, skipping the optional ones by record flags.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TS_IDLE:  if (!fifo_empty || fifo_push) state_d = TS_HDR;
            TS_HDR:   if (fire) state_d = TS_PC;
            TS_PC:    if (fire) state_d = TS_INSTR;
            TS_INSTR: if (fire) begin
                if (head.reg_addr != '0) state_d = TS_RDATA;
                else if (head.mem_wrt)   state_d = TS_MADDR;
                else                     state_d = end_state;
            end
            TS_RDATA: if (fire) state_d = head.mem_wrt ? TS_MADDR : end_state;
            TS_MADDR: if (fire) state_d = TS_MDATA;
            TS_MDATA: if (fire) state_d = end_state;
            default:  state_d = TS_IDLE;
        endcase
    end

    // Outputs decoded one cycle ahead from the next state and next head record.
    always_comb begin
        valid_d = (state_d != TS_IDLE);
        data_d  = '0;
        last_d  = 1'b0;
        if (valid_d) begin
            data_d = trace_word(state_d, head_nxt);
            last_d = trace_is_last(state_d, head_nxt);
        end
    end

    // Sequence counts every commit, dropped or not, so gaps reveal losses.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            seq_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (update_i) begin
                seq_q <= seq_q + SEQ_W'(1);
            end
            if (update_i && !fifo_push) begin
                ovf_q <= 1'b1;
                if (drop_q != {CNT_W{1'b1}}) begin
                    drop_q <= drop_q + CNT_W'(1);
                end
            end
        end
    end

    assign trace_valid_o = valid_q;
    assign trace_data_o  = data_q;
    assign trace_last_o  = last_q;
    assign level_o       = fifo_count;
    assign overflow_o    = ovf_q;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_trace_packer.sv
// Scoreboard bench for trace_packer: expected packet words are queued at capture and matched on handshake.
module tb_trace_packer;

    localparam int unsigned DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        update_i, upd_sat;
    logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  reg_addr_i;
    logic        mem_wrt_i;
    logic        trace_ready_i, ready_sat;
    logic        trace_valid_o, trace_last_o, overflow_o;
    logic [31:0] trace_data_o;
    logic [3:0]  level_o;
    logic [15:0] drop_cnt_o;
    logic        s_valid, s_last, s_ovf;
    logic [31:0] s_data;
    logic [3:0]  s_level;
    logic [3:0]  s_drop;

    always #5 clk_i = ~clk_i;

    trace_packer #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .update_i(update_i),
        .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
        .mem_wrt_i(mem_wrt_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .trace_valid_o(trace_valid_o), .trace_data_o(trace_data_o), .trace_last_o(trace_last_o),
        .trace_ready_i(trace_ready_i), .level_o(level_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o)
    );

    trace_packer #(.DEPTH(DEPTH), .CNT_W(4)) u_sat (
        .clk_i(clk_i), .rstn_i(rstn_i), .update_i(upd_sat),
        .pc_i(pc_i), .instr_i(instr_i), .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
        .mem_wrt_i(mem_wrt_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .trace_valid_o(s_valid), .trace_data_o(s_data), .trace_last_o(s_last),
        .trace_ready_i(ready_sat), .level_o(s_level), .overflow_o(s_ovf),
        .drop_cnt_o(s_drop)
    );

    logic [32:0] exp_q[$];
    int          m_level, m_drops;
    logic [7:0]  m_seq;
    logic        m_ovf;
    logic        hold_chk;
    logic [31:0] held_data;
    int          checks, errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] ins, input logic [4:0] rd,
                           input logic [31:0] rdat, input logic mw, input logic [31:0] ma,
                           input logic [31:0] md);
        pc_i = pc; instr_i = ins; reg_addr_i = rd; reg_data_i = rdat;
        mem_wrt_i = mw; mem_addr_i = ma; mem_data_i = md;
    endtask

    task automatic push_expected();
        logic [31:0] w[$];
        w.push_back({m_seq, 11'd0, reg_addr_i, 6'd0, (reg_addr_i != 5'd0), mem_wrt_i});
        w.push_back(pc_i);
        w.push_back(instr_i);
        if (reg_addr_i != 5'd0) w.push_back(reg_data_i);
        if (mem_wrt_i) begin
            w.push_back(mem_addr_i);
            w.push_back(mem_data_i);
        end
        for (int i = 0; i < w.size(); i++) begin
            exp_q.push_back({(i == w.size() - 1), w[i]});
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        m_level = 0; m_drops = 0; m_seq = 8'd0; m_ovf = 1'b0; hold_chk = 1'b0;
    endtask

    // One cycle: drive at negedge, model the coming edge, check state after it.
    task automatic tick(input logic upd, input logic rdy);
        logic [32:0] e;
        update_i = upd;
        trace_ready_i = rdy;
        #1;
        if (hold_chk) begin
            check("hold_valid", trace_valid_o, 1);
            check("hold_data", trace_data_o, held_data);
        end
        if (trace_valid_o && rdy && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word", {trace_last_o, trace_data_o}, e);
            if (e[32]) m_level--;
        end
        if (upd) begin
            if (m_level < DEPTH) begin
                push_expected();
                m_level++;
            end else begin
                if (m_drops < 65535) m_drops++;
                m_ovf = 1'b1;
            end
            m_seq++;
        end
        hold_chk  = trace_valid_o && !rdy;
        held_data = trace_data_o;
        @(posedge clk_i);
        @(negedge clk_i);
        update_i = 1'b0;
        check("valid", trace_valid_o, exp_q.size() != 0);
        check("level", level_o, m_level);
        check("drops", drop_cnt_o, m_drops);
        check("ovf", overflow_o, m_ovf);
        if (!trace_valid_o) check("idle_data", trace_data_o, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick(1'b0, 1'b1);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        tick(1'b0, 1'b1);
    endtask

    initial begin
        checks = 0; errors = 0;
        rstn_i = 1'b0; update_i = 1'b0; upd_sat = 1'b0;
        trace_ready_i = 1'b0; ready_sat = 1'b0;
        set_rec(0, 0, 0, 0, 0, 0, 0);
        reset_model();
        repeat (2) @(negedge clk_i);
        check("rst_valid", trace_valid_o, 0);
        check("rst_data", trace_data_o, 0);
        check("rst_last", trace_last_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_drop", drop_cnt_o, 0);
        rstn_i = 1'b1;
        @(negedge clk_i);

        // Overflow: 10 commits into a stalled sink.
        for (int i = 0; i < 10; i++) begin
            set_rec(32'h8000_0000 + 32'(i * 4), $urandom, 5'(i), $urandom, 1'b0, 0, 0);
            tick(1'b1, 1'b0);
        end
        check("ovf_level", level_o, 8);
        check("ovf_drops", drop_cnt_o, 2);
        check("ovf_flag", overflow_o, 1);
        drain();

        // Single ALU commit, store without register write, bare commit.
        set_rec(32'h8000_0000, 32'h0050_0093, 5'd1, 32'd5, 1'b0, 0, 0);
        tick(1'b1, 1'b1);
        drain();
        set_rec(32'h8000_0004, 32'h00A1_2023, 5'd0, 0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        tick(1'b1, 1'b1);
        drain();
        set_rec(32'h8000_0008, 32'h0000_0013, 5'd0, 0, 1'b0, 0, 0);
        tick(1'b1, 1'b1);
        drain();

        // Random backpressure with random record shapes.
        for (int i = 0; i < 300; i++) begin
            logic upd;
            upd = ($urandom_range(0, 3) == 0);
            if (upd) set_rec($urandom, $urandom, 5'($urandom_range(0, 31)), $urandom,
                             1'($urandom_range(0, 1)), $urandom, $urandom);
            tick(upd, 1'($urandom_range(0, 1)));
        end
        drain();

        // Sequence wrap with a sink that keeps up.
        for (int i = 0; i < 260; i++) begin
            set_rec($urandom, $urandom, 5'd0, 0, 1'b0, 0, 0);
            tick(1'b1, 1'b1);
            tick(1'b0, 1'b1);
            tick(1'b0, 1'b1);
        end
        drain();

        // Saturating 4-bit drop counter on a permanently stalled instance.
        for (int i = 0; i < 25; i++) begin
            upd_sat = 1'b1;
            @(posedge clk_i);
            @(negedge clk_i);
        end
        upd_sat = 1'b0;
        check("sat_drop", s_drop, 4'hF);
        check("sat_ovf", s_ovf, 1);
        check("sat_level", s_level, 8);

        // Reset once the PC word of a packet has been accepted.
        set_rec(32'h8000_0100, 32'h0010_0113, 5'd2, 32'h1234_5678, 1'b1, 32'h8000_0200, 32'h55AA_55AA);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        check("pre_rst_valid", trace_valid_o, 1);
        rstn_i = 1'b0;
        #1;
        check("mid_rst_valid", trace_valid_o, 0);
        check("mid_rst_data", trace_data_o, 0);
        check("mid_rst_level", level_o, 0);
        check("mid_rst_sat_level", s_level, 0);
        reset_model();
        @(negedge clk_i);
        rstn_i = 1'b1;
        set_rec(32'h8000_0300, 32'h0000_0013, 5'd3, 32'h0000_0042, 1'b0, 0, 0);
        tick(1'b1, 1'b1);
        check("post_rst_hdr", trace_data_o, 32'h0000_0302);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_packer.md
# trace_packer

Retirement-trace capture and serialization stage directly downstream of `core_model`. It samples the per-instruction commit record whenever `update_o` is asserted and buffers records in a small FIFO. Each record is emitted as a variable-length packet of 32-bit words on a ready/valid stream, so the commit log can be drained by a UART, DMA or bench monitor without stalling the core. Drop accounting makes lost records visible.

## Interface
- `DEPTH`, 8, FIFO depth in records; power of two, ≥2.
- `CNT_W`, 16, width of the drop counter.
- `clk_i`  in  1  clock, rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `update_i`  in  1  commit strobe from core; one record per high cycle.
- `pc_i`  in  XLEN  committed PC.
- `instr_i`  in  XLEN  committed instruction word.
- `reg_addr_i`  in  5  destination register; 0 means no register write.
- `reg_data_i`  in  XLEN  value written to `reg_addr_i`.
- `mem_wrt_i`  in  1  instruction performed a store.
- `mem_addr_i`  in  XLEN  store address.
- `mem_data_i`  in  XLEN  store data.
- `trace_valid_o`  out  1  output word valid.
- `trace_data_o`  out  32  output word.
- `trace_last_o`  out  1  marks the final word of a packet.
- `trace_ready_i`  in  1  sink accepts the word.
- `level_o`  out  $clog2(DEPTH)+1  records held, including the one being sent.
- `overflow_o`  out  1  sticky; set on the first dropped record.
- `drop_cnt_o`  out  CNT_W  dropped records; saturates at all-ones.

## Operation
- Capture: a rising edge with `update_i`=1 pushes {seq, pc, instr, reg_addr, reg_data, mem_wrt, mem_addr, mem_data}.
  - Accepted if `level_o`<DEPTH, or if the packet head is popped on the same edge.
  - Otherwise the record is dropped: `drop_cnt_o` increments (saturating) and `overflow_o` is set.
- Sequence: 8-bit `seq` counter, reset 0. It increments on every `update_i` edge, including drops, so gaps in the log expose losses. It wraps 255→0.
- Packet words, in order:
  - HDR: [31:24]=seq, [12:8]=reg_addr, [1]=(reg_addr≠0), [0]=mem_wrt, all other bits 0.
  - PC.
  - INSTR.
  - RDATA, only when reg_addr≠0.
  - MADDR then MDATA, only when mem_wrt=1.
  - Packet length is 3 to 6 words. `trace_last_o` is high on the final word only.
- FSM states and transitions:
  - IDLE: go to HDR when the FIFO is non-empty.
  - HDR → PC → INSTR.
  - INSTR goes to RDATA, MADDR, or the end of the packet, depending on the record flags.
  - RDATA goes to MADDR or the end of the packet.
  - MADDR → MDATA → end of the packet.
  - Advance only on a `trace_valid_o && trace_ready_i` edge.
  - At the end of the packet the head is popped. The FSM goes to HDR if another record is queued, else IDLE.
- Stream rules: once `trace_valid_o` rises, valid and data hold stable until accepted. Valid never depends combinationally on ready.
- `trace_data_o` is 0 when not valid.

## Timing
- Reset values: `trace_valid_o`=0, `trace_data_o`=0, `trace_last_o`=0, `level_o`=0, `overflow_o`=0, `drop_cnt_o`=0. FSM is in IDLE, FIFO pointers are 0, `seq`=0.
- Latency: a record captured at edge N presents its HDR word with valid high in the cycle after edge N, if the FIFO was empty and the FSM was IDLE.
- Throughput: one word per cycle with ready held high. Packets are back-to-back with no idle cycle between them.
- Full with a same-edge push and last-word pop: both occur, and `level_o` stays at DEPTH.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-packet: outputs drop immediately and asynchronously. The partial packet is discarded and not resumed.

## Structure
- Shared package `riscv_pkg` gets:
  - `XLEN` (existing).
  - `trace_rec_t`, a packed struct holding the capture fields.
  - `trace_state_e`, the FSM state enum.
  - Header bit-position localparams.
- Sub-module `sync_fifo`: parameterised on width and depth, single clock. It provides push/pop, full/empty and count, and has no fall-through.
- `trace_packer` contains the FSM, the word mux and the counters.

## Test plan
- Single ALU commit: pc=0x80000000, instr=0x00500093, reg_addr=1, reg_data=5, ready=1 → 4 words: 0x00000102, 0x80000000, 0x00500093, 0x00000005. Last is on word 4.
- Store with no register write: reg_addr=0, mem_wrt=1, addr=0x80000010, data=0xDEADBEEF → 5 words, HDR=0x00000001, last on MDATA. Then a commit with reg_addr=0 and mem_wrt=0 → exactly 3 words.
- Backpressure: ready toggled 1/0 randomly → valid and data stable while ready=0. All words are delivered once, in order.
- Overflow: ready=0, 10 consecutive updates with DEPTH=8 → `level_o`=8, `drop_cnt_o`=2, `overflow_o`=1. After the drain, the HDR seq values read 0..7.
- Seq wrap and saturation: 260 updates with a fast sink → seq reads 0x00 after 0xFF. A forced saturation run with CNT_W=4 and more than 15 drops → `drop_cnt_o` holds 0xF.
- Reset mid-packet after the PC word → next cycle `trace_valid_o`=0 and `level_o`=0. The next capture's HDR seq is 0.
